controle_mux_rr: RTL and testbench
==================================

Name: controle_mux_rr

Overview:
- Round-robin scheduler sharing the 8:1 four-bit selector datapath among eight requesters.
- Each source raises its REQ bit; the block picks one winner, drives the selector code (SEL/ID) and a one-hot grant, and registers the selected 4-bit word onto SAIDA with a valid flag.
- A grant is held for at most HOLD cycles, then rotates.
- Sits between the source interfaces and the shared output bus.

Parameters:
- HOLD, 4, maximum consecutive cycles one requester may keep the grant; legal range 1..16.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- REQ  input  8  request bits; REQ[i] belongs to source i.
- S0..S7  input  4 each  source data words.
- GNT  output  8  one-hot grant; all zero when idle.
- SEL  output  3  selector code of the current/last winner.
- ID  output  3  always equal to SEL.
- SAIDA  output  4  registered data of the granted source; 0 when not valid.
- VALIDO  output  1  high while a grant is active.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset, sampled at a rising edge, forces:
  - state OCIOSO, pointer PTR=0, hold counter CNT=0;
  - outputs GNT=0, SEL=0, ID=0, SAIDA=0, VALIDO=0.
- Reset mid-grant aborts the grant at that edge; no further output change occurs until reset is low.
- Priority pick (combinational): winner W is the first i with REQ[i]=1 in the order PTR, PTR+1, ..., PTR+7 (mod 8).
- States: OCIOSO, CONCEDIDO.
- OCIOSO:
  - REQ==0: stay; VALIDO=0, GNT=0, SAIDA=0; SEL holds its last value.
  - REQ!=0 at edge k: after edge k the block is in CONCEDIDO with SEL=W, GNT=1<<W, VALIDO=1, SAIDA=S[W] (value sampled at edge k), CNT=1.
  - Latency is one clock edge from REQ to grant.
- CONCEDIDO, each edge:
  - Release when REQ[SEL]==0 or CNT==HOLD.
  - No release: SAIDA<=S[SEL] (one-cycle registered copy), CNT<=CNT+1.
  - On release: PTR<=SEL+1 (mod 8), computed before the next pick in the same edge.
  - If REQ has other bits set, the next winner is chosen with the updated PTR in the same edge. Back-to-back grant, no idle cycle; CNT=1; SAIDA<=S[new W].
  - If the only set bit is the current holder (HOLD expiry), it is re-granted, because it is last in the rotated order.
  - If REQ==0: go to OCIOSO; VALIDO=0, GNT=0, SAIDA=0.
- HOLD=1: every grant lasts exactly one cycle, giving strict rotation under full load.
- Simultaneous REQ drop of the holder and a new request from another source: release plus immediate grant to the new source in the same edge.
- Invariants:
  - GNT is one-hot or zero.
  - GNT!=0 if and only if VALIDO=1.
  - ID==SEL at all times.
  - CNT width is clog2(HOLD+1), and CNT never exceeds HOLD.
- Fairness: under continuous requests from all 8 sources, every source is granted within 7*HOLD cycles of its previous grant ending.

Decomposition:
- Package controle_mux_pkg:
  - N_FONTES=8, LARG_SEL=3, LARG_DADO=4;
  - typedef enum logic {OCIOSO, CONCEDIDO} estado_t;
  - typedef logic [LARG_DADO-1:0] dado_t.
- Sub-module seletor_rr_prioridade: purely combinational; takes REQ and PTR; returns W and a found flag.
- The data selection reuses the existing 8:1 selector datapath, driven by SEL.

Test Plan:
- Reset: hold reset 2 cycles with REQ=8'hFF -> GNT=0, SEL=0, SAIDA=0, VALIDO=0 during and on the first edge after reset.
- Single source: REQ=8'h08, S3=4'hA, HOLD=4 -> one edge later GNT=8'h08, SEL=ID=3, SAIDA=A, VALIDO=1. Grant persists past 4 cycles via re-grant, and VALIDO never drops.
- Rotation: REQ=8'h81 constant, PTR=0, HOLD=2 -> source 0 for 2 cycles, then 7 for 2, then 0 again, with no idle cycle between grants.
- Early release: grant source 5, then drop REQ[5] after 1 cycle with REQ=0 -> next edge VALIDO=0, GNT=0, SAIDA=0, SEL stays 5. A new REQ=8'h21 then grants source 0 (PTR=6, wraps to 0 before 5).
- Full load: REQ=8'hFF, HOLD=1 -> SEL sequence 0,1,...,7,0 on consecutive cycles; GNT stays one-hot each cycle.
- Reset mid-grant: assert reset while granting source 2 -> after that edge all outputs are zero. After release, REQ=8'h04 is granted again (PTR restarted at 0).

Source files
------------

// File: rtl/controle_mux_pkg.sv
// Shared types and widths for the round-robin 8:1 selector controller.
package controle_mux_pkg;
  localparam int N_FONTES  = 8;
  localparam int LARG_SEL  = 3;
  localparam int LARG_DADO = 4;

  typedef enum logic {OCIOSO, CONCEDIDO} estado_t;
  typedef logic [LARG_DADO-1:0] dado_t;
  typedef logic [LARG_SEL-1:0]  sel_t;
endpackage

// File: rtl/seletor_rr_prioridade.sv
// Combinational rotating-priority pick: first set request at ptr, ptr+1, ... (mod 8).
module seletor_rr_prioridade
  import controle_mux_pkg::*;
(
  input  logic [N_FONTES-1:0] req,
  input  sel_t                ptr,
  output sel_t                vencedor,
  output logic                achou
);
  sel_t idx;

  // Scan from the far end so the lowest offset from ptr is written last and wins.
  always_comb begin
    vencedor = '0;
    achou    = 1'b0;
    idx      = '0;
    for (int i = N_FONTES-1; i >= 0; i--) begin
      idx = ptr + sel_t'(i);
      if (req[idx]) begin
        vencedor = idx;
        achou    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/controle_mux_rr.sv
// Round-robin grant of the shared 8:1 four-bit selector, with bounded hold time.
module controle_mux_rr
  import controle_mux_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_FONTES-1:0] REQ,
  input  dado_t               S0,
  input  dado_t               S1,
  input  dado_t               S2,
  input  dado_t               S3,
  input  dado_t               S4,
  input  dado_t               S5,
  input  dado_t               S6,
  input  dado_t               S7,
  output logic [N_FONTES-1:0] GNT,
  output sel_t                SEL,
  output sel_t                ID,
  output dado_t               SAIDA,
  output logic                VALIDO
);
  localparam int CW = $clog2(HOLD + 1);

  estado_t         estado, estado_prox;
  sel_t            ptr, ptr_prox, ptr_pick, sel_prox, vencedor;
  logic            achou, liberar;
  logic [CW-1:0]   cnt, cnt_prox;
  dado_t           saida_prox;
  dado_t           dados [N_FONTES];

  assign dados[0] = S0;
  assign dados[1] = S1;
  assign dados[2] = S2;
  assign dados[3] = S3;
  assign dados[4] = S4;
  assign dados[5] = S5;
  assign dados[6] = S6;
  assign dados[7] = S7;

  // On release the pointer moves past the holder before the pick in the same edge.
  assign liberar  = (estado == CONCEDIDO) && (!REQ[SEL] || cnt == CW'(HOLD));
  assign ptr_pick = liberar ? SEL + sel_t'(1) : ptr;

  seletor_rr_prioridade u_sel (
    .req      (REQ),
    .ptr      (ptr_pick),
    .vencedor (vencedor),
    .achou    (achou)
  );

  always_comb begin
    estado_prox = estado;
    ptr_prox    = ptr;
    sel_prox    = SEL;
    cnt_prox    = cnt;
    saida_prox  = SAIDA;
    case (estado)
      OCIOSO: begin
        if (achou) begin
          estado_prox = CONCEDIDO;
          sel_prox    = vencedor;
          cnt_prox    = CW'(1);
          saida_prox  = dados[vencedor];
        end else begin
          cnt_prox   = '0;
          saida_prox = '0;
        end
      end
      CONCEDIDO: begin
        if (!liberar) begin
          cnt_prox   = cnt + CW'(1);
          saida_prox = dados[SEL];
        end else begin
          ptr_prox = ptr_pick;
          if (achou) begin
            sel_prox   = vencedor;
            cnt_prox   = CW'(1);
            saida_prox = dados[vencedor];
          end else begin
            estado_prox = OCIOSO;
            cnt_prox    = '0;
            saida_prox  = '0;
          end
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      ptr    <= '0;
      cnt    <= '0;
      SEL    <= '0;
      SAIDA  <= '0;
    end else begin
      estado <= estado_prox;
      ptr    <= ptr_prox;
      cnt    <= cnt_prox;
      SEL    <= sel_prox;
      SAIDA  <= saida_prox;
    end
  end

  assign VALIDO = (estado == CONCEDIDO);
  assign GNT    = VALIDO ? ({{(N_FONTES-1){1'b0}}, 1'b1} << SEL) : '0;
  assign ID     = SEL;
endmodule

// File: tb/tb_controle_mux_rr.sv
// Randomized and directed bench; three instances (HOLD=1,2,4) share inputs, each against its own model.
module tb_controle_mux_rr;
  logic       clock, reset;
  logic [7:0] req;
  logic [3:0] s [8];
  logic [7:0] gnt [3];
  logic [2:0] sel [3], id [3];
  logic [3:0] saida [3];
  logic       valido [3];

  int n_checks = 0, n_err = 0;
  int hv [3] = '{1, 2, 4};
  int m_act [3], m_ptr [3], m_cnt [3], m_sel [3], m_saida [3];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  controle_mux_rr #(.HOLD(1)) dut0 (.clock(clock), .reset(reset), .REQ(req),
    .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]), .S4(s[4]), .S5(s[5]), .S6(s[6]), .S7(s[7]),
    .GNT(gnt[0]), .SEL(sel[0]), .ID(id[0]), .SAIDA(saida[0]), .VALIDO(valido[0]));
  controle_mux_rr #(.HOLD(2)) dut1 (.clock(clock), .reset(reset), .REQ(req),
    .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]), .S4(s[4]), .S5(s[5]), .S6(s[6]), .S7(s[7]),
    .GNT(gnt[1]), .SEL(sel[1]), .ID(id[1]), .SAIDA(saida[1]), .VALIDO(valido[1]));
  controle_mux_rr #(.HOLD(4)) dut2 (.clock(clock), .reset(reset), .REQ(req),
    .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]), .S4(s[4]), .S5(s[5]), .S6(s[6]), .S7(s[7]),
    .GNT(gnt[2]), .SEL(sel[2]), .ID(id[2]), .SAIDA(saida[2]), .VALIDO(valido[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  // Reference: advance each model by one edge from the current inputs.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        m_act[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; m_sel[d] = 0; m_saida[d] = 0;
      end else if (m_act[d] == 0) begin
        if (req != 0) begin
          m_sel[d] = pick(req, m_ptr[d]);
          m_act[d] = 1; m_cnt[d] = 1; m_saida[d] = int'(s[m_sel[d]]);
        end else m_saida[d] = 0;
      end else if (req[m_sel[d]] && m_cnt[d] < hv[d]) begin
        m_cnt[d]++;
        m_saida[d] = int'(s[m_sel[d]]);
      end else begin
        m_ptr[d] = (m_sel[d] + 1) % 8;
        if (req != 0) begin
          m_sel[d] = pick(req, m_ptr[d]);
          m_cnt[d] = 1; m_saida[d] = int'(s[m_sel[d]]);
        end else begin
          m_act[d] = 0; m_cnt[d] = 0; m_saida[d] = 0;
        end
      end
    end
  endtask

  task automatic step();
    logic [18:0] e, g;
    model_edge();
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      e = {(m_act[d] != 0) ? 8'(1 << m_sel[d]) : 8'h00, 3'(m_sel[d]), 3'(m_sel[d]),
           4'(m_saida[d]), 1'(m_act[d] != 0)};
      g = {gnt[d], sel[d], id[d], saida[d], valido[d]};
      check($sformatf("model_d%0d", d), 32'(g), 32'(e));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'hFF;
    for (int i = 0; i < 8; i++) s[i] = 4'(i + 1);
    // reset with all requests pending
    step();
    check("rst_gnt", 32'(gnt[2]), 32'h0);
    step();
    check("rst_valido", 32'(valido[2]), 32'h0);
    check("rst_saida", 32'(saida[2]), 32'h0);
    reset = 1'b0; req = 8'h00;
    step();
    // single source, HOLD=4 instance
    req = 8'h08; s[3] = 4'hA;
    step();
    check("single_gnt", 32'(gnt[2]), 32'h08);
    check("single_sel", 32'(sel[2]), 32'd3);
    check("single_id", 32'(id[2]), 32'd3);
    check("single_saida", 32'(saida[2]), 32'hA);
    for (int i = 0; i < 6; i++) begin
      step();
      check("single_hold", 32'({valido[2], gnt[2]}), 32'h108);
    end
    // rotation 0/7, HOLD=2 instance
    req = 8'h00; do_reset();
    req = 8'h81;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rot_sel", 32'(sel[1]), (i % 4 < 2) ? 32'd0 : 32'd7);
    end
    // early release then wraparound
    req = 8'h00; do_reset();
    req = 8'h20; step(); step();
    req = 8'h00; step();
    check("early_valido", 32'(valido[2]), 32'h0);
    check("early_sel", 32'(sel[2]), 32'd5);
    check("early_saida", 32'(saida[2]), 32'h0);
    req = 8'h21; step();
    check("wrap_sel", 32'(sel[2]), 32'd0);
    // full load, HOLD=1 instance
    req = 8'h00; do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      check("full_sel", 32'(sel[0]), 32'(i % 8));
      check("full_gnt", 32'(gnt[0]), 32'(1 << (i % 8)));
    end
    // reset in the middle of a grant
    req = 8'h00; do_reset();
    req = 8'h04; step();
    reset = 1'b1; step();
    check("midrst_out", 32'({gnt[2], sel[2], saida[2], valido[2]}), 32'h0);
    reset = 1'b0; step();
    check("midrst_regrant", 32'(gnt[2]), 32'h04);
    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      for (int i = 0; i < 8; i++) s[i] = 4'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
